data_sram_responder: RTL and testbench

//   Target end of the CPU's data SRAM interface: a synchronous single-port word RAM

---
 rtl/data_sram_responder.sv | 127 ++++++++++++
 tb/tb_data_sram_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM target for the CPU: a word RAM with byte write enables, plus an MMIO
// window holding LED, switch, free-running timer and scratch registers.
module data_sram_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_we,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    input  logic [SW_W-1:0]  switch_in,
    output logic [LED_W-1:0] led
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;

    logic [31:0]       mem [DEPTH];

    logic [31:0]       rdata_q,   rdata_d;
    logic [LED_W-1:0]  led_q,     led_d;
    logic [31:0]       timer_q,   timer_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]   sw_sync_q, sw_sync_d;

    logic              mmio_hit;
    logic              do_write;
    logic              ram_wr;
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       reg_off;
    logic [31:0]       led_merged;

    // Each enabled byte lane takes the new data; disabled lanes keep the old value.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign mmio_hit   = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign word_idx   = data_sram_addr[ADDR_W+1:2];
    assign reg_off    = data_sram_addr[15:0] & 16'hFFFC;
    assign do_write   = data_sram_en && (data_sram_we != 4'h0);
    assign led_merged = merge_lanes(32'(led_q), data_sram_wdata, data_sram_we);

    always_comb begin
        // NOTE: every variable gets its hold/default value first so no path can infer a latch.
        rdata_d   = rdata_q;
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        scratch_d = scratch_q;
        sw_meta_d = switch_in;
        sw_sync_d = sw_meta_q;
        ram_wr    = 1'b0;

        if (data_sram_en) begin
            if (mmio_hit) begin
                // Reads sample the pre-edge register value, so a TIMER read sees the old count.
                unique case (reg_off)
                    OFF_LED:     rdata_d = 32'(led_q);
                    OFF_SWITCH:  rdata_d = 32'(sw_sync_q);
                    OFF_TIMER:   rdata_d = timer_q;
                    OFF_SCRATCH: rdata_d = scratch_q;
                    default:     rdata_d = 32'h0;
                endcase
                if (do_write) begin
                    unique case (reg_off)
                        OFF_LED:     led_d     = led_merged[LED_W-1:0];
                        OFF_TIMER:   timer_d   = merge_lanes(timer_q, data_sram_wdata, data_sram_we);
                        OFF_SCRATCH: scratch_d = merge_lanes(scratch_q, data_sram_wdata, data_sram_we);
                        default:     ;
                    endcase
                end
            end else begin
                rdata_d = mem[word_idx];
                ram_wr  = do_write;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= 32'h0;
            led_q     <= '0;
            timer_q   <= 32'h0;
            scratch_q <= 32'h0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto a plain SRAM macro; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a table of single-cycle vectors plus
// hand-written sequences for the timer wrap, switch synchroniser and reset.
module tb_data_sram_responder;

    localparam int ADDR_W = 10;
    localparam int LED_W  = 16;
    localparam int SW_W   = 8;

    localparam logic [31:0] A_LED     = 32'hBFAF_0000;
    localparam logic [31:0] A_SWITCH  = 32'hBFAF_0004;
    localparam logic [31:0] A_TIMER   = 32'hBFAF_0008;
    localparam logic [31:0] A_SCRATCH = 32'hBFAF_000C;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [3:0]       we;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [SW_W-1:0]  switch_in;
    logic [LED_W-1:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic        chk;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[$];

    data_sram_responder #(
        .ADDR_W   (ADDR_W),
        .MMIO_BASE(32'hBFAF_0000),
        .LED_W    (LED_W),
        .SW_W     (SW_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_sram_en   (en),
        .data_sram_we   (we),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .switch_in      (switch_in),
        .led            (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic e, input logic [3:0] w,
                                input logic [31:0] a, input logic [31:0] d, input logic [7:0] sw,
                                input logic c, input logic [31:0] exp_r, input logic [15:0] exp_l);
        vec_t v;
        v.name = name; v.en = e; v.we = w; v.addr = a; v.wdata = d; v.sw = sw;
        v.chk = c; v.exp_rdata = exp_r; v.exp_led = exp_l;
        return v;
    endfunction

    // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input vec_t v);
        @(negedge clk);
        en = v.en; we = v.we; addr = v.addr; wdata = v.wdata; switch_in = v.sw;
        @(posedge clk);
        #1;
        if (v.chk) check(v.name, rdata, v.exp_rdata);
        check({v.name, "_led"}, 32'(led), 32'(v.exp_led));
    endtask

    initial begin
        // RAM: full word, byte lanes, aliasing, read-first, idle hold
        vecs.push_back(mk("ram_wr_full",   1, 4'hF, 32'h40,   32'h1234_5678, 8'h0, 0, 32'h0,         16'h0));
        vecs.push_back(mk("ram_rd_full",   1, 4'h0, 32'h40,   32'h0,         8'h0, 1, 32'h1234_5678, 16'h0));
        vecs.push_back(mk("ram_wr_lanes",  1, 4'h5, 32'h40,   32'hAABB_CCDD, 8'h0, 1, 32'h1234_5678, 16'h0));
        vecs.push_back(mk("ram_rd_lanes",  1, 4'h0, 32'h40,   32'h0,         8'h0, 1, 32'h12BB_56DD, 16'h0));
        vecs.push_back(mk("alias_wr",      1, 4'hF, 32'h1040, 32'hCAFE_F00D, 8'h0, 1, 32'h12BB_56DD, 16'h0));
        vecs.push_back(mk("alias_rd",      1, 4'h0, 32'h40,   32'h0,         8'h0, 1, 32'hCAFE_F00D, 16'h0));
        vecs.push_back(mk("ram_clr80",     1, 4'hF, 32'h80,   32'h0,         8'h0, 0, 32'h0,         16'h0));
        vecs.push_back(mk("rw_same_cycle", 1, 4'hF, 32'h80,   32'hFFFF_FFFF, 8'h0, 1, 32'h0,         16'h0));
        vecs.push_back(mk("idle_hold",     0, 4'hF, 32'h80,   32'h0001_2345, 8'h0, 1, 32'h0,         16'h0));
        vecs.push_back(mk("rd_after_rw",   1, 4'h0, 32'h80,   32'h0,         8'h0, 1, 32'hFFFF_FFFF, 16'h0));
        vecs.push_back(mk("near_miss_dec", 1, 4'h0, 32'hBFAE_0040, 32'h0,    8'h0, 1, 32'hCAFE_F00D, 16'h0));
        // MMIO: scratch, unmapped offset, LED, read-only switch
        vecs.push_back(mk("scr_wr_full",   1, 4'hF, A_SCRATCH, 32'hDEAD_BEEF, 8'h0, 1, 32'h0,         16'h0));
        vecs.push_back(mk("scr_wr_lane3",  1, 4'h8, A_SCRATCH, 32'h1100_0000, 8'h0, 1, 32'hDEAD_BEEF, 16'h0));
        vecs.push_back(mk("scr_rd",        1, 4'h0, A_SCRATCH, 32'h0,         8'h0, 1, 32'h11AD_BEEF, 16'h0));
        vecs.push_back(mk("unmapped_wr",   1, 4'hF, 32'hBFAF_0010, 32'h7777_7777, 8'h0, 1, 32'h0,    16'h0));
        vecs.push_back(mk("unmapped_rd",   1, 4'h0, 32'hBFAF_0010, 32'h0,     8'h0, 1, 32'h0,         16'h0));
        vecs.push_back(mk("led_wr",        1, 4'hF, A_LED, 32'h0001_A5A5,     8'h0, 1, 32'h0,         16'hA5A5));
        vecs.push_back(mk("led_rd",        1, 4'h0, A_LED, 32'h0,             8'h0, 1, 32'h0000_A5A5, 16'hA5A5));
        vecs.push_back(mk("led_wr_lane1",  1, 4'h2, A_LED, 32'h0000_3C00,     8'h0, 1, 32'h0000_A5A5, 16'h3CA5));
        vecs.push_back(mk("led_rd2",       1, 4'h0, A_LED, 32'h0,             8'h0, 1, 32'h0000_3CA5, 16'h3CA5));
        vecs.push_back(mk("sw_wr_ignored", 1, 4'hF, A_SWITCH, 32'hFFFF_FFFF,  8'h0, 1, 32'h0,         16'h3CA5));
        vecs.push_back(mk("sw_rd_zero",    1, 4'h0, A_SWITCH, 32'h0,          8'h0, 1, 32'h0,         16'h3CA5));

        reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; switch_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", 32'(led), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Timer: load near the top, let it wrap, then a single-lane load over the count
        step(mk("tmr_load",   1, 4'hF, A_TIMER, 32'hFFFF_FFFE, 8'h0, 0, 32'h0,         16'h3CA5));
        step(mk("tmr_idle",   0, 4'h0, A_TIMER, 32'h0,         8'h0, 0, 32'h0,         16'h3CA5));
        step(mk("tmr_rd_max", 1, 4'h0, A_TIMER, 32'h0,         8'h0, 1, 32'hFFFF_FFFF, 16'h3CA5));
        step(mk("tmr_rd_wrap",1, 4'h0, A_TIMER, 32'h0,         8'h0, 1, 32'h0,         16'h3CA5));
        step(mk("tmr_wr_lane",1, 4'h1, A_TIMER, 32'hAAAA_AA05, 8'h0, 1, 32'h1,         16'h3CA5));
        step(mk("tmr_rd_lane",1, 4'h0, A_TIMER, 32'h0,         8'h0, 1, 32'h5,         16'h3CA5));

        // Switch: value changes with the first read, visible only to reads issued two edges later
        step(mk("sw_sync_0",  1, 4'h0, A_SWITCH, 32'h0, 8'h3C, 1, 32'h0,         16'h3CA5));
        step(mk("sw_sync_1",  1, 4'h0, A_SWITCH, 32'h0, 8'h3C, 1, 32'h0,         16'h3CA5));
        step(mk("sw_sync_2",  1, 4'h0, A_SWITCH, 32'h0, 8'h3C, 1, 32'h0000_003C, 16'h3CA5));

        // Reset in the middle of an LED read: outputs clear without waiting for an edge
        @(negedge clk);
        en = 1'b1; we = 4'h0; addr = A_LED; reset = 1'b1;
        #1;
        check("rst_async_led", 32'(led), 32'h0);
        check("rst_async_rdata", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; en = 1'b1; we = 4'h0; addr = A_TIMER;
        @(posedge clk);
        #1;
        check("rst_tmr_rd0", rdata, 32'h0);
        step(mk("rst_tmr_rd1", 1, 4'h0, A_TIMER,   32'h0, 8'h3C, 1, 32'h1,         16'h0));
        step(mk("rst_scr_rd",  1, 4'h0, A_SCRATCH, 32'h0, 8'h3C, 1, 32'h0,         16'h0));
        step(mk("rst_ram_kept",1, 4'h0, 32'h40,    32'h0, 8'h3C, 1, 32'hCAFE_F00D, 16'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
